// File: rtl/seg_pkg.sv
// Shared constants and types for the time-multiplexed seven-segment scanner.
// All segment patterns are active-low: a 0 bit lights the segment.
package seg_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Index is the decimal digit; bit 0 is segment a, bit 6 is segment g.
    localparam logic [6:0] SEG_CODE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_SLOT0 = 4'b0111;
    localparam logic [3:0] AN_SLOT1 = 4'b1011;
    localparam logic [3:0] AN_SLOT2 = 4'b1101;
    localparam logic [3:0] AN_SLOT3 = 4'b1110;

    function automatic logic [3:0] slot_anode(input slot_t s);
        case (s)
            2'd0:    return AN_SLOT0;
            2'd1:    return AN_SLOT1;
            2'd2:    return AN_SLOT2;
            default: return AN_SLOT3;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Digit bus from the stopwatch counter plus the display pins it ends up on.
// The scanner consumes the slave side; whoever feeds digits holds the master side.
interface seg_scan_if;

    logic [4:0] min_l;
    logic [4:0] min_r;
    logic [4:0] sec_l;
    logic [4:0] sec_r;
    logic       adj;
    logic [2:0] adj_sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (
        output min_l, min_r, sec_l, sec_r, adj, adj_sel,
        input  seg, dp, an
    );

    modport slave (
        input  min_l, min_r, sec_l, sec_r, adj, adj_sel,
        output seg, dp, an
    );

endinterface

// File: rtl/seg_decode.sv
// Combinational digit-to-segment decoder; anything outside 0..9 shows a dash
// so a corrupted counter value is visible instead of silently wrong.
module seg_decode
    import seg_pkg::*;
(
    input  logic [4:0] val,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (val < 5'd10) begin
            seg = SEG_CODE[val[3:0]];
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed display driver: per-slot scanning with a blank guard,
// frame-coherent digit snapshot and blinking of the digit under adjustment.
module seg_scan
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0] GUARD_END    = RW'(GUARD);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt;
    slot_t         slot;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic [4:0]    sh_dig [4];
    logic          sh_adj;
    logic [2:0]    sh_sel;

    logic          slot_end;
    logic          frame_end;
    logic          guard;
    logic          blank_digit;
    logic [4:0]    cur_dig;
    logic [6:0]    dec_seg;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign slot_end  = (refresh_cnt == REFRESH_LAST);
    assign frame_end = slot_end && (slot == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            slot        <= 2'd0;
        end else if (slot_end) begin
            refresh_cnt <= '0;
            slot        <= slot + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Latch a whole frame's worth of inputs at once so a rollover never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_dig <= '{default: '0};
            sh_adj <= 1'b0;
            sh_sel <= 3'd0;
        end else if (frame_end) begin
            sh_dig[0] <= bus.min_l;
            sh_dig[1] <= bus.min_r;
            sh_dig[2] <= bus.sec_l;
            sh_dig[3] <= bus.sec_r;
            sh_adj    <= bus.adj;
            sh_sel    <= bus.adj_sel;
        end
    end

    // Held in the visible phase outside adjust so entering adjust starts lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!sh_adj) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign cur_dig = sh_dig[slot];

    seg_decode u_decode (
        .val (cur_dig),
        .seg (dec_seg)
    );

    assign guard       = (refresh_cnt < GUARD_END);
    assign blank_digit = sh_adj && (sh_sel == {1'b0, slot}) && !blink_on;

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!guard) begin
            an_d  = slot_anode(slot);
            seg_d = blank_digit ? SEG_BLANK : dec_seg;
            dp_d  = (slot != 2'd1);
        end
    end

    // Output pin registers: one cycle behind the scan counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an  <= AN_OFF;
            bus.seg <= SEG_BLANK;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= an_d;
            bus.seg <= seg_d;
            bus.dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: a cycle-indexed behavioural model of the display plus
// directed literal checks and a randomized input phase.
module tb_seg_scan;

    localparam int RD    = 8;
    localparam int GD    = 2;
    localparam int BD    = 64;
    localparam int FRAME = 4 * RD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic run_chk = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: k = clock edges since reset release (index of the current cycle).
    int k = 0;
    int sh_dig [4];
    int sh_adj = 0;
    int sh_sel = 0;
    int adj_start = 0;
    logic [3:0] exp_an  = 4'hF;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp  = 1'b1;

    seg_scan_if bus ();

    seg_scan #(
        .REFRESH_DIV (RD),
        .GUARD       (GD),
        .BLINK_DIV   (BD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_seg(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    // Expected pins for cycle k+1 are a function of the scan position in cycle k.
    initial begin
        int r;
        int s;
        logic [6:0] code;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0;
                sh_dig = '{default: 0};
                sh_adj = 0;
                sh_sel = 0;
                adj_start = 0;
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                r = k % RD;
                s = (k / RD) % 4;
                if (r < GD) begin
                    exp_an  = 4'hF;
                    exp_seg = 7'h7F;
                    exp_dp  = 1'b1;
                end else begin
                    exp_an = ~(4'b1000 >> s);
                    code = model_seg(sh_dig[s]);
                    if (sh_adj != 0 && sh_sel == s && ((k - adj_start) / BD) % 2 == 1)
                        code = 7'h7F;
                    exp_seg = code;
                    exp_dp  = (s == 1) ? 1'b0 : 1'b1;
                end
                if (k % FRAME == FRAME - 1) begin
                    sh_dig[0] = int'(bus.min_l);
                    sh_dig[1] = int'(bus.min_r);
                    sh_dig[2] = int'(bus.sec_l);
                    sh_dig[3] = int'(bus.sec_r);
                    if (bus.adj && sh_adj == 0) adj_start = k + 1;
                    sh_adj = int'(bus.adj);
                    sh_sel = int'(bus.adj_sel);
                end
                k++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (run_chk) begin
                chk("an", 32'(bus.an), 32'(exp_an));
                chk("seg", 32'(bus.seg), 32'(exp_seg));
                chk("dp", 32'(bus.dp), 32'(exp_dp));
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, k=%0d", k);
        $fatal(1, "watchdog");
    end

    // Returns at the negedge where the pins show scan position (slot, r).
    task automatic at_out(input int slot, input int r);
        @(negedge clk);
        while (k % FRAME != (slot * RD + r + 1) % FRAME) @(negedge clk);
    endtask

    task automatic wait_snap();
        at_out(3, RD - 1);
    endtask

    initial begin
        logic [4:0] v;
        bus.min_l = 5'd1;
        bus.min_r = 5'd2;
        bus.sec_l = 5'd3;
        bus.sec_r = 5'd4;
        bus.adj = 1'b0;
        bus.adj_sel = 3'd0;

        repeat (3) @(negedge clk);
        run_chk = 1'b1;
        chk("reset_an", 32'(bus.an), 32'hF);
        chk("reset_seg", 32'(bus.seg), 32'h7F);
        chk("reset_dp", 32'(bus.dp), 32'h1);
        rst_n = 1'b1;

        // Frame 1 shows the reset shadow, frame 2 the inputs.
        at_out(0, 4);
        chk("f1_s0_an", 32'(bus.an), 32'b0111);
        chk("f1_s0_seg", 32'(bus.seg), 32'h40);
        at_out(0, 0);
        chk("f2_guard0_an", 32'(bus.an), 32'hF);
        at_out(0, 1);
        chk("f2_guard1_an", 32'(bus.an), 32'hF);
        chk("f2_guard1_seg", 32'(bus.seg), 32'h7F);
        at_out(0, 2);
        chk("f2_s0_an", 32'(bus.an), 32'b0111);
        chk("f2_s0_seg", 32'(bus.seg), 32'h79);
        chk("f2_s0_dp", 32'(bus.dp), 32'h1);
        at_out(1, 4);
        chk("f2_s1_an", 32'(bus.an), 32'b1011);
        chk("f2_s1_seg", 32'(bus.seg), 32'h24);
        chk("f2_s1_dp", 32'(bus.dp), 32'h0);
        at_out(2, 4);
        chk("f2_s2_an", 32'(bus.an), 32'b1101);
        chk("f2_s2_seg", 32'(bus.seg), 32'h30);
        at_out(3, 4);
        chk("f2_s3_an", 32'(bus.an), 32'b1110);
        chk("f2_s3_seg", 32'(bus.seg), 32'h19);

        // sec_r 9 -> 0 mid-frame must not tear; then out-of-range value.
        bus.sec_r = 5'd9;
        wait_snap();
        at_out(1, 2);
        bus.sec_r = 5'd0;
        at_out(3, 4);
        chk("tear_hold_seg", 32'(bus.seg), 32'h10);
        wait_snap();
        at_out(3, 4);
        chk("tear_next_seg", 32'(bus.seg), 32'h40);
        bus.sec_r = 5'd12;
        wait_snap();
        at_out(3, 4);
        chk("dash_seg", 32'(bus.seg), 32'h3F);

        // Blink slot 2: visible for 64 cycles from the snapshot, then blank.
        bus.min_l = 5'd5;
        bus.sec_l = 5'd7;
        bus.adj = 1'b1;
        bus.adj_sel = 3'd2;
        wait_snap();
        at_out(2, 4);
        chk("blink_vis_seg", 32'(bus.seg), 32'h78);
        chk("blink_vis_an", 32'(bus.an), 32'b1101);
        at_out(0, 4);
        chk("blink_other0_seg", 32'(bus.seg), 32'h12);
        at_out(2, 4);
        chk("blink_vis2_seg", 32'(bus.seg), 32'h78);
        at_out(2, 4);
        chk("blink_off_seg", 32'(bus.seg), 32'h7F);
        chk("blink_off_an", 32'(bus.an), 32'b1101);
        at_out(0, 4);
        chk("blink_other1_seg", 32'(bus.seg), 32'h12);

        // adj_sel out of range highlights nothing.
        bus.adj_sel = 3'd5;
        wait_snap();
        repeat (3) begin
            at_out(2, 4);
            chk("sel5_seg", 32'(bus.seg), 32'h78);
        end

        // Asynchronous reset in the slot 2 active phase.
        at_out(2, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", 32'(bus.an), 32'hF);
        chk("async_rst_seg", 32'(bus.seg), 32'h7F);
        chk("async_rst_dp", 32'(bus.dp), 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        at_out(1, 4);
        chk("post_rst_seg", 32'(bus.seg), 32'h40);

        // Randomized inputs, including illegal digits and mid-frame adj changes.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 3) == 0) v = 5'($urandom_range(0, 31));
                else v = 5'($urandom_range(0, 9));
                case ($urandom_range(0, 3))
                    0: bus.min_l = v;
                    1: bus.min_r = v;
                    2: bus.sec_l = v;
                    default: bus.sec_r = v;
                endcase
            end
            if ($urandom_range(0, 199) == 0) bus.adj = ~bus.adj;
            if ($urandom_range(0, 149) == 0) bus.adj_sel = 3'($urandom_range(0, 7));
        end

        @(negedge clk);
        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
